// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int unsigned DefMemBytes   = 32;
  localparam int unsigned DefMemLatency = 2;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: on a tie the port not served last wins.
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  input  logic       en_i,
  output logic [1:0] gnt_o,
  output logic       valid_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      unique case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = (last_grant_i == M1) ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
    valid_o = |gnt_o;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and fixed-latency access sequencer for the shared data memory.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MEM_BYTES   = DefMemBytes,
  parameter int unsigned MEM_LATENCY = DefMemLatency
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_rdata_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned CntW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MEM_LATENCY - 1);
  localparam logic [31:0] MaxAddr = 32'(MEM_BYTES - 4);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            gnt_q, gnt_d;
  logic            last_q, last_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [1:0]      ack_q, ack_d;
  logic [1:0]      err_q, err_d;
  logic [31:0]     rdata_q [2];
  logic [31:0]     rdata_d [2];

  logic [1:0]  arb_gnt;
  logic        arb_valid;
  logic        sel;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;

  rr_arbiter2 u_arb (
    .req_i        ({m1_req_i, m0_req_i}),
    .last_grant_i (last_q),
    .en_i         (state_q == StIdle),
    .gnt_o        (arb_gnt),
    .valid_o      (arb_valid)
  );

  always_comb begin
    unique case (arb_gnt)
      2'b10:   sel = M1;
      default: sel = M0;
    endcase
    sel_we    = (sel == M1) ? m1_we_i    : m0_we_i;
    sel_addr  = (sel == M1) ? m1_addr_i  : m0_addr_i;
    sel_wdata = (sel == M1) ? m1_wdata_i : m0_wdata_i;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ack_d   = 2'b00;
    err_d   = 2'b00;
    rdata_d = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          gnt_d   = sel;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          cnt_d   = '0;
          // Out-of-range requests skip the memory and answer immediately.
          if (sel_addr > MaxAddr) begin
            state_d    = StResp;
            ack_d[sel] = 1'b1;
            err_d[sel] = 1'b1;
          end else begin
            state_d = StAccess;
          end
        end
      end
      StAccess: begin
        if (cnt_q == CntLast) begin
          state_d      = StResp;
          cnt_d        = '0;
          ack_d[gnt_q] = 1'b1;
          if (!we_q) rdata_d[gnt_q] = mem_rdata_i;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        last_d  = gnt_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      gnt_q      <= M0;
      last_q     <= M1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ack_q      <= 2'b00;
      err_q      <= 2'b00;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdata_q[0] <= rdata_d[0];
      rdata_q[1] <= rdata_d[1];
    end
  end

  assign m0_ack_o    = ack_q[0];
  assign m1_ack_o    = ack_q[1];
  assign m0_err_o    = err_q[0];
  assign m1_err_o    = err_q[1];
  assign m0_rdata_o  = rdata_q[0];
  assign m1_rdata_o  = rdata_q[1];
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_read_o  = (state_q == StAccess) && !we_q;
  assign mem_write_o = (state_q == StAccess) && we_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int unsigned MB = 32;
  localparam int Li = 2;
  localparam logic [31:0] MaxA = 32'(MB - 4);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  dmem_arbiter #(.MEM_BYTES(MB), .MEM_LATENCY(Li)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_rdata_o(m1_rdata),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_read_o(mem_read),
    .mem_write_o(mem_write), .mem_rdata_i(mem_rdata)
  );

  // Byte-wide memory attached to the main instance.
  logic [7:0] pmem [MB];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(MB); i++) pmem[i] <= 8'h00;
    end else if (mem_write) begin
      for (int b = 0; b < 4; b++)
        if (mem_addr + 32'(b) < MB) pmem[5'(mem_addr + 32'(b))] <= mem_wdata[8*b +: 8];
    end
  end
  always_comb begin
    mem_rdata = '0;
    for (int b = 0; b < 4; b++)
      if (mem_addr + 32'(b) < MB) mem_rdata[8*b +: 8] = pmem[5'(mem_addr + 32'(b))];
  end

  // Latency-1 and latency-3 instances for back-to-back throughput.
  logic        b_req;
  logic        q1_ack, q1_err, q1_m1_ack, q1_m1_err, q1_rd, q1_wr;
  logic [31:0] q1_rdata, q1_m1_rdata, q1_maddr, q1_mwdata, q1_mrdata;
  logic        q3_ack, q3_err, q3_m1_ack, q3_m1_err, q3_rd, q3_wr;
  logic [31:0] q3_rdata, q3_m1_rdata, q3_maddr, q3_mwdata, q3_mrdata;
  assign q1_mrdata = q1_maddr ^ 32'h5A5A_0000;
  assign q3_mrdata = q3_maddr ^ 32'h5A5A_0000;

  dmem_arbiter #(.MEM_BYTES(MB), .MEM_LATENCY(1)) dut_l1 (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(b_req), .m0_we_i(1'b0), .m0_addr_i(32'd20), .m0_wdata_i(32'd0),
    .m0_ack_o(q1_ack), .m0_err_o(q1_err), .m0_rdata_o(q1_rdata),
    .m1_req_i(1'b0), .m1_we_i(1'b0), .m1_addr_i(32'd0), .m1_wdata_i(32'd0),
    .m1_ack_o(q1_m1_ack), .m1_err_o(q1_m1_err), .m1_rdata_o(q1_m1_rdata),
    .mem_addr_o(q1_maddr), .mem_wdata_o(q1_mwdata), .mem_read_o(q1_rd),
    .mem_write_o(q1_wr), .mem_rdata_i(q1_mrdata)
  );

  dmem_arbiter #(.MEM_BYTES(MB), .MEM_LATENCY(3)) dut_l3 (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(b_req), .m0_we_i(1'b0), .m0_addr_i(32'd20), .m0_wdata_i(32'd0),
    .m0_ack_o(q3_ack), .m0_err_o(q3_err), .m0_rdata_o(q3_rdata),
    .m1_req_i(1'b0), .m1_we_i(1'b0), .m1_addr_i(32'd0), .m1_wdata_i(32'd0),
    .m1_ack_o(q3_m1_ack), .m1_err_o(q3_m1_err), .m1_rdata_o(q3_m1_rdata),
    .mem_addr_o(q3_maddr), .mem_wdata_o(q3_mwdata), .mem_read_o(q3_rd),
    .mem_write_o(q3_wr), .mem_rdata_i(q3_mrdata)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: memory image, per-port last read data, last served port.
  logic [7:0]  rmem [MB];
  logic [31:0] exp_rd [2];
  int          m_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(MB); i++) rmem[i] = 8'h00;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    m_last = 1;
  endtask

  task automatic model_access(input int p, input bit we, input logic [31:0] a,
                              input logic [31:0] d);
    int ai;
    if (a <= MaxA) begin
      ai = int'(a);
      if (we) for (int b = 0; b < 4; b++) rmem[ai+b] = d[8*b +: 8];
      else exp_rd[p] = {rmem[ai+3], rmem[ai+2], rmem[ai+1], rmem[ai]};
    end
    m_last = p;
  endtask

  // One transaction per active port; m1 may be raised dly1 cycles after m0.
  task automatic run(input bit act0, input bit we0, input logic [31:0] a0, input logic [31:0] dv0,
                     input bit act1, input bit we1, input logic [31:0] a1, input logic [31:0] dv1,
                     input int dly1);
    int dur0, dur1, exp_t0, exp_t1, t0, t1, strb, exp_strb, extra;
    bit done0, done1, first1, e0, e1;
    logic [31:0] r0, r1;
    dur0 = (a0 > MaxA) ? 1 : Li + 1;
    dur1 = (a1 > MaxA) ? 1 : Li + 1;
    first1 = act1 && (!act0 || (dly1 == 0 && m_last == 0));
    if (act0 && act1) begin
      if (!first1) begin
        exp_t0 = dur0;
        exp_t1 = ((dly1 > dur0 + 1) ? dly1 : dur0 + 1) + dur1;
      end else begin
        exp_t1 = dur1;
        exp_t0 = dur1 + 1 + dur0;
      end
    end else begin
      exp_t0 = dur0;
      exp_t1 = dly1 + dur1;
    end
    exp_strb = ((act0 && a0 <= MaxA) ? Li : 0) + ((act1 && a1 <= MaxA) ? Li : 0);
    if (first1) begin
      model_access(1, we1, a1, dv1);
      if (act0) model_access(0, we0, a0, dv0);
    end else begin
      if (act0) model_access(0, we0, a0, dv0);
      if (act1) model_access(1, we1, a1, dv1);
    end

    t0 = -1; t1 = -1; strb = 0; extra = 0; e0 = 0; e1 = 0; r0 = '0; r1 = '0;
    done0 = !act0; done1 = !act1;
    m0_we = we0; m0_addr = a0; m0_wdata = dv0; m0_req = act0;
    m1_we = we1; m1_addr = a1; m1_wdata = dv1; m1_req = act1 && (dly1 == 0);
    for (int k = 1; k <= 60 && !(done0 && done1); k++) begin
      @(posedge clk); #1;
      chk("strobe_excl", 32'(mem_read & mem_write), 32'd0);
      strb += int'(mem_read | mem_write);
      if (m0_ack) begin
        if (done0) extra++;
        else begin t0 = k; e0 = m0_err; r0 = m0_rdata; done0 = 1; m0_req = 0; end
      end
      if (m1_ack) begin
        if (done1) extra++;
        else begin t1 = k; e1 = m1_err; r1 = m1_rdata; done1 = 1; m1_req = 0; end
      end
      if (act1 && dly1 > 0 && k == dly1) m1_req = 1;
    end
    if (act0) begin
      chk("m0_ack_cycle", t0, exp_t0);
      chk("m0_err", 32'(e0), 32'(a0 > MaxA));
      chk("m0_rdata", r0, exp_rd[0]);
    end
    if (act1) begin
      chk("m1_ack_cycle", t1, exp_t1);
      chk("m1_err", 32'(e1), 32'(a1 > MaxA));
      chk("m1_rdata", r1, exp_rd[1]);
    end
    chk("extra_ack", extra, 0);
    chk("strobe_cycles", strb, exp_strb);
    m0_req = 0;
    m1_req = 0;
    @(posedge clk); #1;
    chk("ack_pulse_width", {30'd0, m1_ack, m0_ack}, 32'd0);
    chk("m0_rdata_hold", m0_rdata, exp_rd[0]);
    chk("m1_rdata_hold", m1_rdata, exp_rd[1]);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 8) return 32'($urandom_range(0, MB - 4));
    if (r == 8) return 32'($urandom_range(MB - 3, 64));
    return 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int q1t[$];
    int q3t[$];
    int m1_seen;
    bit a0b, a1b;
    int d1;

    rst = 1; b_req = 0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_acks", {28'd0, m1_err, m0_err, m1_ack, m0_ack}, 32'd0);
    chk("rst_strobes", {30'd0, mem_write, mem_read}, 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    chk("rst_m1_rdata", m1_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 0;

    // Simultaneous reads straight out of reset: m0 first, then strict alternation.
    run(1, 0, 32'd0, 32'd0, 1, 0, 32'd4, 32'd0, 0);
    run(1, 0, 32'd0, 32'd0, 1, 0, 32'd4, 32'd0, 0);

    run(1, 1, 32'd8, 32'hDEAD_BEEF, 0, 0, 32'd0, 32'd0, 0);
    chk("mem_byte8", 32'(pmem[8]), 32'hEF);
    chk("mem_byte9", 32'(pmem[9]), 32'hBE);
    chk("mem_byte10", 32'(pmem[10]), 32'hAD);
    chk("mem_byte11", 32'(pmem[11]), 32'hDE);
    run(1, 0, 32'd8, 32'd0, 0, 0, 32'd0, 32'd0, 0);
    chk("m0_read_deadbeef", m0_rdata, 32'hDEAD_BEEF);

    // Out-of-range m1 read, then m0 served next.
    run(0, 0, 32'd0, 32'd0, 1, 0, 32'd29, 32'd0, 0);
    run(1, 0, 32'd9, 32'd0, 1, 0, 32'd8, 32'd0, 0);

    // m1 write arrives while m0 is mid-access.
    run(1, 0, 32'd8, 32'd0, 1, 1, 32'd16, 32'h1234_5678, 1);
    run(0, 0, 32'd0, 32'd0, 1, 0, 32'd16, 32'd0, 0);

    // Reset in the second ACCESS cycle aborts the access.
    m0_we = 0; m0_addr = 32'd8; m0_req = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_reset_read_strobe", 32'(mem_read), 32'd1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0; m0_req = 0;
    model_reset();
    chk("abort_strobes", {30'd0, mem_write, mem_read}, 32'd0);
    chk("abort_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
    chk("abort_m0_rdata", m0_rdata, 32'd0);
    chk("abort_mem_addr", mem_addr, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("abort_no_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
    end
    run(1, 1, 32'd4, 32'hAABB_CCDD, 0, 0, 32'd0, 32'd0, 0);
    run(1, 0, 32'd4, 32'd0, 1, 0, 32'd6, 32'd0, 0);

    for (int it = 0; it < 40; it++) begin
      a0b = 1'($urandom_range(0, 1));
      a1b = !a0b || 1'($urandom_range(0, 1));
      d1 = (a0b && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      run(a0b, 1'($urandom_range(0, 1)), rand_addr(), $urandom,
          a1b, 1'($urandom_range(0, 1)), rand_addr(), $urandom, d1);
    end

    // Back-to-back reads on the latency-1 and latency-3 instances.
    m1_seen = 0;
    b_req = 1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (q1_ack) begin
        q1t.push_back(k);
        chk("l1_rdata", q1_rdata, 32'd20 ^ 32'h5A5A_0000);
      end
      if (q3_ack) begin
        q3t.push_back(k);
        chk("l3_rdata", q3_rdata, 32'd20 ^ 32'h5A5A_0000);
      end
      m1_seen += int'(q1_m1_ack | q3_m1_ack | q1_err | q3_err);
    end
    b_req = 0;
    chk("l1_ack_count_ok", 32'(q1t.size() >= 3), 32'd1);
    chk("l3_ack_count_ok", 32'(q3t.size() >= 3), 32'd1);
    if (q1t.size() >= 3) begin
      chk("l1_first_ack", q1t[0], 32'd2);
      chk("l1_spacing_a", q1t[1] - q1t[0], 32'd3);
      chk("l1_spacing_b", q1t[2] - q1t[1], 32'd3);
    end
    if (q3t.size() >= 3) begin
      chk("l3_first_ack", q3t[0], 32'd4);
      chk("l3_spacing_a", q3t[1] - q3t[0], 32'd5);
      chk("l3_spacing_b", q3t[2] - q3t[1], 32'd5);
    end
    chk("b2b_m1_or_err_activity", m1_seen, 32'd0);
    chk("l1_m1_rdata", q1_m1_rdata, 32'd0);
    chk("l3_m1_rdata", q3_m1_rdata, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port round-robin arbiter and access sequencer for the shared byte-addressed data memory. Sits between two requesters, m0 (pipeline load/store path) and m1 (debug/DMA loader), and the single memory port. It grants one requester at a time and holds the memory strobes for a fixed access latency. It then returns read data with a one-cycle acknowledge. Out-of-range accesses are rejected without touching memory.

## Interface
Parameters:
- MEM_BYTES, 32, memory size in bytes; little-endian, 4-byte word accesses
- MEM_LATENCY, 2, cycles the memory strobes are held per access (≥1)

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- m0_req_i / m1_req_i  in  1  access request; held high until the matching ack
- m0_we_i / m1_we_i  in  1  1 = write, 0 = read; stable while req high
- m0_addr_i / m1_addr_i  in  32  byte address of the word's lowest byte
- m0_wdata_i / m1_wdata_i  in  32  write data
- m0_ack_o / m1_ack_o  out  1  one-cycle completion pulse
- m0_err_o / m1_err_o  out  1  valid with ack; 1 = address out of range, no access made
- m0_rdata_o / m1_rdata_o  out  32  read data; valid with ack, held until that port's next read ack
- mem_addr_o  out  32  address to memory
- mem_wdata_o  out  32  write data to memory
- mem_read_o / mem_write_o  out  1  memory strobes; never both high
- mem_rdata_i  in  32  read data from memory

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE.
  - One requester: grant it.
  - Both requesting: grant the port not served last. last_grant resets to m1, so m0 wins the first tie.
  - Latch the granted port's addr, we and wdata into internal registers.
- Range check at grant:
  - Error when addr > MEM_BYTES-4, using the full 32-bit compare; no wrap.
  - Error request: go straight to RESP with err=1; strobes stay low.
- ACCESS:
  - mem_addr_o and mem_wdata_o come from the latched registers.
  - Exactly one of mem_read_o or mem_write_o is high, per latched we.
  - Counter counts MEM_LATENCY cycles. On the last ACCESS cycle, capture mem_rdata_i into the granted port's rdata register (reads only).
- RESP:
  - Granted port's ack_o = 1 and err_o is valid. Strobes are low.
  - Update last_grant, including for error responses. Go to IDLE.
- Requester must drop req the cycle after ack. A still-high req is treated as a new request.
- Addresses are not alignment-checked. Any in-range byte address is passed through as given.
- Request inputs are ignored outside IDLE. A request arriving mid-access waits.

## Timing
- Request sampled high in IDLE at cycle n:
  - Strobes high in cycles n+1 … n+MEM_LATENCY.
  - ack in cycle n+MEM_LATENCY+1.
  - Back-to-back throughput is one access per MEM_LATENCY+2 cycles.
- Error path: ack+err at cycle n+1.
- Reset values:
  - state = IDLE, counter = 0, last_grant = m1.
  - All ack_o, err_o, mem_read_o and mem_write_o = 0.
  - Both rdata_o = 0, mem_addr_o = 0, mem_wdata_o = 0.
- Reset asserted mid-ACCESS or mid-RESP: strobes and ack drop the next edge. No ack is issued for the aborted access.
- ack_o and err_o are registered outputs. Strobes are decoded from registered state.

## Structure
- Package dmem_arb_pkg: state enum (IDLE, ACCESS, RESP), port-index constants M0=0, M1=1, default MEM_BYTES / MEM_LATENCY.
- Sub-module rr_arbiter2: inputs req[1:0], last_grant and an enable (IDLE). Outputs a one-hot grant and a valid flag. Purely combinational; last_grant stays in the top-level FSM.

## Test plan
- m0 write 0xDEADBEEF to addr 8, then m0 read addr 8 -> memory bytes 8..11 = EF BE AD DE; rdata 0xDEADBEEF with ack at n+MEM_LATENCY+1; err=0.
- m0 and m1 request reads in the same cycle right after reset, both held -> m0 acked first, m1 next; repeat -> strict alternation.
- m1 read addr 29 (MEM_BYTES=32) -> ack+err at n+1, mem strobes never high; following m0 request is granted next.
- m1 write during an m0 ACCESS -> m1 strobes start only after m0 ack; m0 read data unaffected.
- rst_i pulsed during cycle 2 of ACCESS -> no ack, strobes low the next edge, outputs at reset values; new request afterward completes normally.
- Back-to-back m0 reads with MEM_LATENCY=1 and 3 -> ack spacing 3 and 5 cycles; m1 rdata_o unchanged throughout.
